// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
// Optional feature macro used by this slice: REG_FILE_BYPASS_EN.
package reg_file_pkg;

  typedef enum logic [0:0] {
    CLR = 1'b0,
    RUN = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_ADDR  = 0;

  // Per-entry write source select
  localparam logic [1:0] WSEL_NONE = 2'b00;
  localparam logic [1:0] WSEL_P0   = 2'b01;
  localparam logic [1:0] WSEL_P1   = 2'b10;

  // Decide which write port (if any) updates entry idx this cycle.
  // Port 1 wins a same-address collision; a hardwired zero entry is never written.
  function automatic logic [1:0] entry_wr_sel(
    input int   idx,
    input logic we0,
    input int   waddr0,
    input logic we1,
    input int   waddr1,
    input int   zero_reg
  );
    logic [1:0] sel;
    if ((zero_reg != 0) && (idx == ZERO_ADDR)) begin
      sel = WSEL_NONE;
    end else if (we1 && (waddr1 == idx)) begin
      sel = WSEL_P1;
    end else if (we0 && (waddr0 == idx)) begin
      sel = WSEL_P0;
    end else begin
      sel = WSEL_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: array mux, zero-register and clear masking,
// and (when REG_FILE_BYPASS_EN is defined) write-to-read forwarding.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic [DATA_W-1:0] mem [2**ADDR_W],
  input  logic              init_busy,
`ifdef REG_FILE_BYPASS_EN
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
`endif
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] raw_s;
  logic              zero_hit_s;

  assign zero_hit_s = (ZERO_REG != 0) && (raddr == ADDR_W'(ZERO_ADDR));

  // Select array data, forwarding in-flight write data when bypass is built in
  always_comb begin
    raw_s = mem[raddr];
`ifdef REG_FILE_BYPASS_EN
    if (we1 && (waddr1 == raddr)) begin
      raw_s = wdata1;
    end else if (we0 && (waddr0 == raddr)) begin
      raw_s = wdata0;
    end else begin
      raw_s = mem[raddr];
    end
`endif
  end

  // Force zero while clearing and for the hardwired zero entry
  always_comb begin
    rdata = raw_s;
    if (init_busy || zero_hit_s) begin
      rdata = {DATA_W{1'b0}};
    end else begin
      rdata = raw_s;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file: NUM_RD read ports, two write ports
// (port 1 has priority), optional hardwired zero entry, post-reset clear
// sequencer. Define REG_FILE_BYPASS_EN to forward write data to same-cycle reads.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic                     init_busy
);

  localparam int DEPTH = 2**ADDR_W;

  localparam logic [0:0] ST_CLR = CLR;
  localparam logic [0:0] ST_RUN = RUN;

  logic [0:0]        state_r;
  logic [ADDR_W-1:0] clr_idx_r;
  logic              init_busy_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              clr_wr_s;
  logic              we0_s;
  logic              we1_s;

  // Writes only take effect out of reset; the clear step owns the array in CLR
  assign clr_wr_s = rstn && (state_r == ST_CLR);
  assign we0_s    = we0 && rstn && (state_r == ST_RUN);
  assign we1_s    = we1 && rstn && (state_r == ST_RUN);

  assign init_busy = init_busy_r;

  // Clear sequencer: walk every entry once after reset, then enter RUN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= ST_CLR;
      clr_idx_r   <= {ADDR_W{1'b0}};
      init_busy_r <= 1'b1;
    end else begin
      case (state_r)
        ST_CLR: begin
          clr_idx_r <= clr_idx_r + ADDR_W'(1);
          if (clr_idx_r == ADDR_W'(DEPTH - 1)) begin
            state_r     <= ST_RUN;
            init_busy_r <= 1'b0;
          end else begin
            state_r     <= ST_CLR;
            init_busy_r <= 1'b1;
          end
        end
        ST_RUN: begin
          state_r     <= ST_RUN;
          clr_idx_r   <= clr_idx_r;
          init_busy_r <= 1'b0;
        end
        default: begin
          state_r     <= ST_CLR;
          clr_idx_r   <= {ADDR_W{1'b0}};
          init_busy_r <= 1'b1;
        end
      endcase
    end
  end

  // Array update: no bulk reset, so it can map onto a RAM
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (clr_wr_s && (int'(clr_idx_r) == i)) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end else begin
        case (entry_wr_sel(i, we0_s, int'(waddr0), we1_s, int'(waddr1), ZERO_REG))
          WSEL_P1: mem_r[i] <= wdata1;
          WSEL_P0: mem_r[i] <= wdata0;
          default: mem_r[i] <= mem_r[i];
        endcase
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    reg_file_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .mem       (mem_r),
      .init_busy (init_busy_r),
`ifdef REG_FILE_BYPASS_EN
      .we0       (we0_s),
      .waddr0    (waddr0),
      .wdata0    (wdata0),
      .we1       (we1_s),
      .waddr1    (waddr1),
      .wdata1    (wdata1),
`endif
      .raddr     (raddr[k*ADDR_W +: ADDR_W]),
      .rdata     (rdata[k*DATA_W +: DATA_W])
    );
  end

endmodule
